// File: rtl/regf_multi.sv
// Multi-read-port register file with RAW pending scoreboard and a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding: define REGF_BYPASS_EN.

module regf_multi_rdport #(
   parameter int DW = 32
) (
   input  logic          run_i,
   input  logic          zero_i,
   input  logic [DW-1:0] ent_val_i,
   input  logic          ent_pend_i,
   input  logic          byp_hit_i,
   input  logic [DW-1:0] byp_val_i,
   input  logic          byp_pend_i,
   output logic [DW-1:0] rd_val_o,
   output logic          rd_pend_o
);
   always_comb begin
      rd_val_o  = '0;
      rd_pend_o = 1'b0;
      if (run_i && !zero_i) begin
         if (byp_hit_i) begin
            rd_val_o  = byp_val_i;
            rd_pend_o = byp_pend_i;
         end else begin
            rd_val_o  = ent_val_i;
            rd_pend_o = ent_pend_i;
         end
      end
   end
endmodule

module regf_multi #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int NRD     = 2,
   parameter int ZERO_R0 = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NRD*AW-1:0] i_rd_idx,
   output logic [NRD*DW-1:0] o_rd_val,
   output logic [NRD-1:0]    o_rd_pend,
   input  logic              i_wb_en,
   input  logic [AW-1:0]     i_wb_reg,
   input  logic [DW-1:0]     i_wb_val,
   input  logic              i_alloc_en,
   input  logic [AW-1:0]     i_alloc_reg,
   output logic              o_busy
);
   localparam int DEPTH = 2**AW;

   typedef enum logic {S_CLEAR, S_RUN} state_e;

   state_e            state_q;
   logic [AW-1:0]     cnt_q;
   logic              busy_q;
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [DW-1:0]     mem_q [DEPTH];

   logic              run;
   logic              wb_ok, alloc_ok;
   logic              mem_we;
   logic [AW-1:0]     mem_wa;
   logic [DW-1:0]     mem_wd;

   assign run      = (state_q == S_RUN);
   assign wb_ok    = i_wb_en    && !((ZERO_R0 != 0) && (i_wb_reg    == '0));
   assign alloc_ok = i_alloc_en && !((ZERO_R0 != 0) && (i_alloc_reg == '0));
   assign o_busy   = busy_q;

   // Wb clears first so a same-edge allocation to the same register wins.
   always_comb begin
      pend_d = pend_q;
      if (wb_ok)    pend_d[i_wb_reg]    = 1'b0;
      if (alloc_ok) pend_d[i_alloc_reg] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         pend_q  <= '0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b0;
               end
            end
            S_RUN: pend_q <= pend_d;
            default: state_q <= S_CLEAR;
         endcase
      end
   end

   // Single write port shared by the sweep and write-back; no reset so it can map to RAM.
   assign mem_we = run ? wb_ok    : 1'b1;
   assign mem_wa = run ? i_wb_reg : cnt_q;
   assign mem_wd = run ? i_wb_val : '0;

   always_ff @(posedge i_clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] idx;
      logic          byp_hit, byp_pend;
      assign idx = i_rd_idx[k*AW +: AW];
`ifdef REGF_BYPASS_EN
      assign byp_hit  = wb_ok && (i_wb_reg == idx);
      assign byp_pend = alloc_ok && (i_alloc_reg == idx);
`else
      assign byp_hit  = 1'b0;
      assign byp_pend = 1'b0;
`endif
      regf_multi_rdport #(.DW(DW)) u_rd (
         .run_i      (run),
         .zero_i     ((ZERO_R0 != 0) && (idx == '0)),
         .ent_val_i  (mem_q[idx]),
         .ent_pend_i (pend_q[idx]),
         .byp_hit_i  (byp_hit),
         .byp_val_i  (i_wb_val),
         .byp_pend_i (byp_pend),
         .rd_val_o   (o_rd_val[k*DW +: DW]),
         .rd_pend_o  (o_rd_pend[k])
      );
   end

endmodule
